// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, combinational MEM resolve/flush, update on clk edge.
// Optional perf counters enabled by defining BPU_PERF_CNT_EN; otherwise the count outputs are tied to zero.
module branch_predict_unit #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            mem_is_branch,
    input  logic            mem_zero,
    input  logic [XLEN-1:0] mem_pc_branch,
    input  logic [XLEN-1:0] mem_pc4,
    input  logic            mem_pred_taken,
    output logic            flush_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispredict_cnt_o
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic             if_hit;
    logic             actual;
    logic [XLEN-1:0]  bpc;
    logic [IDX_W-1:0] mem_idx;
    logic [TAG_W-1:0] mem_tag;
    logic             mem_hit;
    logic [1:0]       ctr_nxt;
    logic             unused_lsb;

    // IF lookup reads the registered state only, so a same-cycle update is seen next cycle.
    assign if_idx        = pc_if[IDX_W+1:2];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == pc_if[XLEN-1:IDX_W+2]);
    assign pred_taken_o  = if_hit && ctr_q[if_idx][1];
    assign pred_target_o = if_hit ? target_q[if_idx] : '0;

    assign actual        = mem_is_branch && mem_zero;
    assign flush_o       = mem_is_branch && (actual != mem_pred_taken);
    assign redirect_pc_o = flush_o ? (actual ? mem_pc_branch : mem_pc4) : '0;

    assign bpc     = mem_pc4 - XLEN'(4);
    assign mem_idx = bpc[IDX_W+1:2];
    assign mem_tag = bpc[XLEN-1:IDX_W+2];
    assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

    assign unused_lsb = &{1'b0, bpc[1:0], pc_if[1:0]};

    always_comb begin
        ctr_nxt = ctr_q[mem_idx];
        if (actual) begin
            if (ctr_q[mem_idx] != 2'b11) ctr_nxt = ctr_q[mem_idx] + 2'b01;
        end else begin
            if (ctr_q[mem_idx] != 2'b00) ctr_nxt = ctr_q[mem_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (mem_is_branch) begin
            if (mem_hit) begin
                ctr_q[mem_idx] <= ctr_nxt;
                if (actual) target_q[mem_idx] <= mem_pc_branch;
            end else begin
                // Miss replaces whatever lived at this index, including an aliasing branch.
                valid_q[mem_idx]  <= 1'b1;
                tag_q[mem_idx]    <= mem_tag;
                target_q[mem_idx] <= mem_pc_branch;
                ctr_q[mem_idx]    <= actual ? 2'b10 : 2'b01;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (mem_is_branch) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (flush_o) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    assign branch_cnt_o     = 32'h0;
    assign mispredict_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized bench for branch_predict_unit against a table-based reference predictor.
module tb_branch_predict_unit;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        mem_is_branch;
    logic        mem_zero;
    logic [31:0] mem_pc_branch;
    logic [31:0] mem_pc4;
    logic        mem_pred_taken;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    int checks = 0;
    int failures = 0;

    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    always #5 clk = ~clk;

    branch_predict_unit #(.IDX_W(4), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_if            (pc_if),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .mem_is_branch    (mem_is_branch),
        .mem_zero         (mem_zero),
        .mem_pc_branch    (mem_pc_branch),
        .mem_pc4          (mem_pc4),
        .mem_pred_taken   (mem_pred_taken),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'h0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 1;
        end
        m_bcnt = 32'h0;
        m_mcnt = 32'h0;
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    task automatic model_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
        bit hit;
        hit   = m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 6));
        taken = hit && (m_ctr[slot(pc)] >= 2);
        tgt   = hit ? m_target[slot(pc)] : 32'h0;
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef BPU_PERF_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Called just after a rising edge: drives one cycle, checks mid-cycle, then advances the model with the edge.
    task automatic step(input logic [31:0] pcif, input bit br, input bit z, input bit pred,
                        input logic [31:0] pc4, input logic [31:0] pcb);
        bit          e_taken, actual, fl, hit;
        logic [31:0] e_tgt, rd, bpc;
        int          i;
        pc_if = pcif; mem_is_branch = br; mem_zero = z; mem_pred_taken = pred;
        mem_pc4 = pc4; mem_pc_branch = pcb;
        #2;
        model_lookup(pcif, e_taken, e_tgt);
        actual = br && z;
        fl     = br && (actual != pred);
        rd     = fl ? (actual ? pcb : pc4) : 32'h0;
        chk("pred_taken", {31'h0, pred_taken_o}, {31'h0, e_taken});
        chk("pred_target", pred_target_o, e_tgt);
        chk("flush", {31'h0, flush_o}, {31'h0, fl});
        chk("redirect_pc", redirect_pc_o, rd);
        chk("branch_cnt", branch_cnt_o, exp_cnt(m_bcnt));
        chk("mispredict_cnt", mispredict_cnt_o, exp_cnt(m_mcnt));
        @(posedge clk);
        if (br) begin
            bpc = pc4 - 32'd4;
            i   = slot(bpc);
            hit = m_valid[i] && (m_tag[i] == (bpc >> 6));
            if (hit) begin
                m_ctr[i] = actual ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                  : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (actual) m_target[i] = pcb;
            end else begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = bpc >> 6;
                m_target[i] = pcb;
                m_ctr[i]    = actual ? 2 : 1;
            end
            m_bcnt = m_bcnt + 32'd1;
        end
        if (fl) m_mcnt = m_mcnt + 32'd1;
        #1;
    endtask

    task automatic peek(input logic [31:0] pcif);
        pc_if = pcif; mem_is_branch = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] rpc, rpc4;
        bit          rt;
        logic [31:0] rtg;
        rst_n = 1'b0;
        pc_if = 32'h100; mem_is_branch = 1'b0; mem_zero = 1'b0; mem_pred_taken = 1'b0;
        mem_pc4 = 32'h0; mem_pc_branch = 32'h0;
        model_reset();
        #12;
        chk("rst_pred_taken", {31'h0, pred_taken_o}, 32'h0);
        chk("rst_pred_target", pred_target_o, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_redirect", redirect_pc_o, 32'h0);
        chk("rst_branch_cnt", branch_cnt_o, 32'h0);
        chk("rst_mispredict_cnt", mispredict_cnt_o, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold taken branch allocates with ctr=2.
        step(32'h100, 1, 1, 0, 32'h104, 32'h200);
        peek(32'h100);
        chk("cold_pred_taken", {31'h0, pred_taken_o}, 32'h1);
        chk("cold_pred_target", pred_target_o, 32'h200);

        // Not-taken edges saturate the counter at 0.
        step(32'h100, 1, 0, 1, 32'h104, 32'h200);
        step(32'h100, 1, 0, 1, 32'h104, 32'h200);
        step(32'h100, 1, 0, 1, 32'h104, 32'h200);
        peek(32'h100);
        chk("sat0_pred_taken", {31'h0, pred_taken_o}, 32'h0);
        step(32'h100, 0, 0, 0, 32'h0, 32'h0);

        // Aliasing: 0x140 shares the index of 0x100 and evicts it.
        step(32'h100, 1, 1, 0, 32'h104, 32'h200);
        step(32'h100, 1, 1, 0, 32'h104, 32'h200);
        peek(32'h100);
        chk("alias_trained", {31'h0, pred_taken_o}, 32'h1);
        step(32'h140, 1, 0, 1, 32'h144, 32'h300);
        peek(32'h100);
        chk("alias_evicted_taken", {31'h0, pred_taken_o}, 32'h0);
        chk("alias_evicted_target", pred_target_o, 32'h0);

        // Same-cycle IF lookup and MEM update on one index.
        step(32'h100, 1, 1, 0, 32'h104, 32'h240);
        step(32'h100, 1, 0, 1, 32'h104, 32'h240);
        peek(32'h100);
        chk("same_cycle_after", {31'h0, pred_taken_o}, 32'h0);

        // Asynchronous reset mid-cycle with a trained entry.
        step(32'h100, 1, 1, 0, 32'h104, 32'h260);
        step(32'h100, 1, 1, 1, 32'h104, 32'h260);
        pc_if = 32'h100; mem_is_branch = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pred_taken", {31'h0, pred_taken_o}, 32'h0);
        chk("midrst_pred_target", pred_target_o, 32'h0);
        chk("midrst_branch_cnt", branch_cnt_o, 32'h0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Three branches, two mispredicts.
        step(32'h0, 1, 1, 0, 32'h84, 32'h400);
        step(32'h0, 1, 1, 1, 32'h84, 32'h400);
        step(32'h0, 1, 0, 1, 32'h84, 32'h400);
        peek(32'h0);
`ifdef BPU_PERF_CNT_EN
        chk("perf_branch_cnt", branch_cnt_o, 32'd3);
        chk("perf_mispredict_cnt", mispredict_cnt_o, 32'd2);
`else
        chk("perf_branch_cnt_off", branch_cnt_o, 32'd0);
        chk("perf_mispredict_cnt_off", mispredict_cnt_o, 32'd0);
`endif

        // Randomized traffic on a small set of aliasing PCs, including the wrap case pc4=0.
        for (int n = 0; n < 500; n++) begin
            rpc = 32'h1000 | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            rpc4 = rpc + 32'd4;
            model_lookup(rpc, rt, rtg);
            if ($urandom_range(0, 3) == 0) rt = 1'($urandom);
            step($urandom_range(0, 1) ? rpc
                 : (32'h1000 | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2)),
                 ($urandom_range(0, 3) != 0), 1'($urandom), rt, rpc4, $urandom & 32'hFFFF_FFFC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
